// File: rtl/grain_keystream_gen.sv
// Grain-style keystream generator: 80-bit LFSR and 24-bit NFSR clocked together,
// with a nonlinear filter producing one keystream bit per state.
module grain_keystream_gen (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Par_load,
    input  logic        shift_en,
    input  logic [79:0] SEED_l,
    input  logic [23:0] SEED_n,
    output logic [79:0] X_l,
    output logic [23:0] X_n,
    output logic        main_output
);

    logic [79:0] lfsr_q, lfsr_d;
    logic [23:0] nfsr_q, nfsr_d;
    logic        fb_l, fb_n, filt_h;
    logic        x0, x1, x2, x3, x4;

    always_comb begin
        x0 = lfsr_q[3];
        x1 = lfsr_q[25];
        x2 = lfsr_q[46];
        x3 = lfsr_q[64];
        x4 = nfsr_q[13];

        fb_l = lfsr_q[0] ^ lfsr_q[13] ^ lfsr_q[23] ^ lfsr_q[38] ^ lfsr_q[51] ^ lfsr_q[62];
        fb_n = lfsr_q[0] ^ nfsr_q[0] ^ nfsr_q[5] ^ nfsr_q[9] ^ nfsr_q[14] ^ nfsr_q[20]
             ^ (nfsr_q[3] & nfsr_q[11]) ^ (nfsr_q[17] & nfsr_q[22]);

        // Filter grouped by shared factors; expands to the ten-term ANF of h.
        filt_h = x1 ^ x4
               ^ (x3 & (x0 ^ x2 ^ x4))
               ^ (x0 & x2 & (x1 ^ x3 ^ x4))
               ^ (x2 & x4 & (x1 ^ x3));

        main_output = nfsr_q[1] ^ nfsr_q[7] ^ nfsr_q[19] ^ filt_h;
    end

    always_comb begin
        lfsr_d = lfsr_q;
        nfsr_d = nfsr_q;
        if (Par_load) begin
            lfsr_d = SEED_l;
            nfsr_d = SEED_n;
        end else if (shift_en) begin
            lfsr_d = {fb_l, lfsr_q[79:1]};
            nfsr_d = {fb_n, nfsr_q[23:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            lfsr_q <= '0;
            nfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            nfsr_q <= nfsr_d;
        end
    end

    assign X_l = lfsr_q;
    assign X_n = nfsr_q;

endmodule

// File: tb/tb_grain_keystream_gen.sv
// Scoreboard bench for grain_keystream_gen: a reference model pushes the expected
// state/keystream bit per edge, compared one cycle later against the DUT.
module tb_grain_keystream_gen;

    logic        Clk;
    logic        reset;
    logic        Par_load;
    logic        shift_en;
    logic [79:0] SEED_l;
    logic [23:0] SEED_n;
    logic [79:0] X_l;
    logic [23:0] X_n;
    logic        main_output;

    grain_keystream_gen dut (
        .Clk(Clk), .reset(reset), .Par_load(Par_load), .shift_en(shift_en),
        .SEED_l(SEED_l), .SEED_n(SEED_n), .X_l(X_l), .X_n(X_n),
        .main_output(main_output)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic [79:0] m_l;
    logic [23:0] m_n;
    logic [104:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_out(input logic [79:0] s, input logic [23:0] b);
        logic a0, a1, a2, a3, a4, h;
        a0 = s[3]; a1 = s[25]; a2 = s[46]; a3 = s[64]; a4 = b[13];
        h = a1 ^ a4 ^ (a0 & a3) ^ (a2 & a3) ^ (a3 & a4) ^ (a0 & a1 & a2)
          ^ (a0 & a2 & a3) ^ (a0 & a2 & a4) ^ (a1 & a2 & a4) ^ (a2 & a3 & a4);
        return b[1] ^ b[7] ^ b[19] ^ h;
    endfunction

    task automatic ref_step(input logic rb, input logic pl, input logic se,
                            input logic [79:0] sl, input logic [23:0] sn);
        logic fl, fn;
        logic [79:0] s;
        logic [23:0] b;
        s = m_l; b = m_n;
        if (!rb) begin
            m_l = '0; m_n = '0;
        end else if (pl) begin
            m_l = sl; m_n = sn;
        end else if (se) begin
            fl = s[0] ^ s[13] ^ s[23] ^ s[38] ^ s[51] ^ s[62];
            fn = s[0] ^ b[0] ^ b[5] ^ b[9] ^ b[14] ^ b[20] ^ (b[3] & b[11]) ^ (b[17] & b[22]);
            for (int i = 0; i < 79; i++) m_l[i] = s[i+1];
            m_l[79] = fl;
            for (int i = 0; i < 23; i++) m_n[i] = b[i+1];
            m_n[23] = fn;
        end
    endtask

    // One clock: drive at negedge, queue the model's expectation, check after the edge.
    task automatic drive(input string tag, input logic rb, input logic pl, input logic se,
                         input logic [79:0] sl, input logic [23:0] sn);
        logic [104:0] e;
        @(negedge Clk);
        reset = rb; Par_load = pl; shift_en = se; SEED_l = sl; SEED_n = sn;
        ref_step(rb, pl, se, sl, sn);
        exp_q.push_back({m_l, m_n, ref_out(m_l, m_n)});
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {23'd0, X_l, X_n, main_output}, {23'd0, e});
        end
    endtask

    int ones, zeros;
    int tr_dut[4];
    int tr_ref[4];
    logic prev_d, prev_r;

    initial begin
        m_l = '0; m_n = '0;
        reset = 1'b0; Par_load = 1'b0; shift_en = 1'b0; SEED_l = '0; SEED_n = '0;

        drive("rst_init", 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_out", {127'd0, main_output}, 128'd0);
        drive("pre_rst_load", 1'b1, 1'b1, 1'b0, 80'hFFFF_0000_AAAA_5555_1234, 24'hABCDEF);
        drive("rst_pl_se", 1'b0, 1'b1, 1'b1, 80'hDEAD_BEEF_0000_1111_2222, 24'h123456);
        chk("rst_xl", {48'd0, X_l}, 128'd0);

        drive("load", 1'b1, 1'b1, 1'b0, 80'h123456789ABCDEF12345, 24'h9a172d);
        chk("load_xl", {48'd0, X_l}, {48'd0, 80'h123456789ABCDEF12345});
        chk("load_xn", {104'd0, X_n}, {104'd0, 24'h9a172d});

        drive("ld_one", 1'b1, 1'b1, 1'b0, 80'h1, 24'h0);
        chk("ld_one_out", {127'd0, main_output}, 128'd0);
        drive("shift1", 1'b1, 1'b0, 1'b1, 80'h0, 24'h0);
        chk("shift1_xl", {48'd0, X_l}, {48'd0, 80'h80000000000000000000});
        chk("shift1_xn", {104'd0, X_n}, {104'd0, 24'h800000});
        chk("shift1_out", {127'd0, main_output}, 128'd0);

        drive("tap_b1", 1'b1, 1'b1, 1'b0, 80'h0, 24'h000002);
        chk("tap_b1_out", {127'd0, main_output}, 128'd1);
        drive("tap_b13", 1'b1, 1'b1, 1'b0, 80'h0, 24'h002000);
        chk("tap_b13_out", {127'd0, main_output}, 128'd1);

        drive("hold_ld", 1'b1, 1'b1, 1'b0, 80'hCAFE_F00D_1357_9BDF_2468, 24'h5A5A5A);
        for (int i = 0; i < 5; i++) begin
            drive("hold", 1'b1, 1'b0, 1'b0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 24'hFFFFFF);
            chk("hold_xl", {48'd0, X_l}, {48'd0, 80'hCAFE_F00D_1357_9BDF_2468});
        end
        drive("prio", 1'b1, 1'b1, 1'b1, 80'h0F0F_0F0F_0F0F_0F0F_0F0F, 24'h3C3C3C);
        chk("prio_xl", {48'd0, X_l}, {48'd0, 80'h0F0F_0F0F_0F0F_0F0F_0F0F});
        chk("prio_xn", {104'd0, X_n}, {104'd0, 24'h3C3C3C});

        drive("lr_load", 1'b1, 1'b1, 1'b0, 80'h123456789ABCDEF12345, 24'h9a172d);
        ones = 0; zeros = 0;
        for (int k = 0; k < 4; k++) begin tr_dut[k] = 0; tr_ref[k] = 0; end
        prev_d = main_output;
        prev_r = ref_out(m_l, m_n);
        if (main_output) ones++; else zeros++;
        for (int i = 0; i < 999; i++) begin
            drive("lr_step", 1'b1, 1'b0, 1'b1, $urandom(), 24'(i));
            if (main_output) ones++; else zeros++;
            tr_dut[{prev_d, main_output}]++;
            tr_ref[{prev_r, ref_out(m_l, m_n)}]++;
            prev_d = main_output;
            prev_r = ref_out(m_l, m_n);
        end
        chk("lr_ones_bal", {127'd0, (ones >= 400 && ones <= 600)}, 128'd1);
        chk("lr_zeros_bal", {127'd0, (zeros >= 400 && zeros <= 600)}, 128'd1);
        chk("lr_tr00", 128'(tr_dut[0]), 128'(tr_ref[0]));
        chk("lr_tr01", 128'(tr_dut[1]), 128'(tr_ref[1]));
        chk("lr_tr10", 128'(tr_dut[2]), 128'(tr_ref[2]));
        chk("lr_tr11", 128'(tr_dut[3]), 128'(tr_ref[3]));
        chk("q_drained", 128'(exp_q.size()), 128'd0);

        drive("rst_mid", 1'b0, 1'b0, 1'b1, 80'h0, 24'h0);
        chk("rst_mid_out", {127'd0, main_output}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
